uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Synthesizable UART receiver; the receive-side counterpart to the existing `tx` transmitter.
- Deserializes an 8N1-plus-odd-parity frame into a byte: start bit, 8 data bits LSB first, 1 odd-parity bit, 1 stop bit.
- Sits between the board RX pin and the byte-stream consumer.
- Frame format and baud timing match `tx`, so `tx` can drive it directly in loopback benches.

Parameters:
- CLK_FREQUENCY, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 19_200: line rate in bits per second.
- BAUD_CLOCKS (localparam) = CLK_FREQUENCY/BAUD_RATE, 5208 at defaults: clocks per bit.
- HALF_BAUD (localparam) = BAUD_CLOCKS/2, 2604 at defaults.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- rx_in  in  1  serial line; asynchronous to clk; idles high.
- dout  out  8  last received byte.
- data_strobe  out  1  one-cycle pulse: dout and rx_error were updated this cycle.
- busy  out  1  high while a frame is being received.
- rx_error  out  1  parity or framing error on the last strobed frame.

Behaviour:
- Reset values: dout=0, data_strobe=0, busy=0, rx_error=0, state=IDLE. Synchronizer flops reset to 1. armed=0.
- rx_in passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s only.
- armed flag: set when rx_s=1 is seen in IDLE; cleared on entering START. A line held low at reset release, or after a framing error, never starts a frame until it returns high.
- Single down-counter of width clog2(BAUD_CLOCKS). bit_cnt is 0..7.
- IDLE: busy=0.
  - rx_s=0 with armed=1 -> START, counter=HALF_BAUD-1.
- START: on counter expiry, sample rx_s.
  - 1 -> false start: back to IDLE, no strobe.
  - 0 -> DATA, counter=BAUD_CLOCKS-1, bit_cnt=0.
- DATA: on each counter expiry (mid-bit), shift rx_s into shift register LSB-first and reload counter.
  - After bit_cnt=7 -> PARITY.
- PARITY: on expiry, sample the parity bit.
  - perr = ~(^{shift,rx_s}), i.e. the total number of ones must be odd.
  - Go to STOP.
- STOP: on expiry, sample the stop bit.
  - In the same cycle: dout<=shift, data_strobe=1, rx_error<=perr | ~rx_s.
  - Go to IDLE.
- busy=1 in START, DATA, PARITY and STOP.
- rx_error holds until the next strobe. dout holds between strobes. dout is updated even on an error.
- Latency: data_strobe rises 2+HALF_BAUD+10*BAUD_CLOCKS (±2) clocks after the falling edge of the start bit on rx_in.
- Mid-bit sampling tolerates ±4% baud mismatch. No oversampling or majority vote.
- Back-to-back frames: a start edge is accepted in the first cycle after STOP (stop bit still high, so armed=1).
- Reset mid-frame: immediate return to IDLE with reset values. The remainder of the interrupted frame is ignored until the line goes high. The next full frame is received correctly.

Test Plan:
- Reset: rx_in=1, rst low 80ns -> dout=0x00, busy=0, data_strobe=0, rx_error=0 two clocks after release.
- Frame 0xA5 with parity=1 at 19200 baud -> one-cycle data_strobe, dout=0xA5, rx_error=0. busy is high for about 10.5 bit times.
- Loopback with `tx`: 20 random bytes with random 1000–30000-clock gaps, plus 4 frames sent back-to-back -> every dout matches the byte sent, rx_error=0 on all.
- Parity error: 0x3C sent with parity=0 -> dout=0x3C, rx_error=1. A following correct frame 0x3C with parity=1 -> rx_error=0.
- Framing error: 0x55 sent with stop=0 and the line held low for 3 bit times -> strobe with rx_error=1 and exactly one strobe. Line then returns high; frame 0x12 -> dout=0x12, rx_error=0.
- Glitch and reset: a 1000-clock low pulse -> busy pulses, no strobe. Reset asserted 4 bit times into frame 0xA5 -> busy=0 after reset, no strobe for that frame, next frame 0x5A received cleanly.

Source files
------------

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line input and received-byte outputs of uart_rx.
//                master = receiver side, slave = line driver / byte consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic       rx_in;        // serial line, idles high, asynchronous to clk
  logic [7:0] dout;         // last received byte
  logic       data_strobe;  // one-cycle pulse: dout/rx_error just updated
  logic       busy;         // frame reception in progress
  logic       rx_error;     // parity or framing error on last strobed frame

  modport master (
    input  rx_in,
    output dout,
    output data_strobe,
    output busy,
    output rx_error
  );

  modport slave (
    output rx_in,
    input  dout,
    input  data_strobe,
    input  busy,
    input  rx_error
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver for start + 8 data (LSB first) + odd parity +
//                stop frames. Mid-bit sampling from a single down-counter,
//                2-flop input synchronizer, re-arm only after an idle-high line.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic       clk,
  input  logic       rst,   // asynchronous, active low
  uart_rx_if.master  bus
);

  localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BAUD   = BAUD_CLOCKS / 2;
  localparam int CNT_W       = (BAUD_CLOCKS > 2) ? $clog2(BAUD_CLOCKS) : 1;

  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(BAUD_CLOCKS - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(HALF_BAUD - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // synchronizer and settle tracking
  logic             rx_meta_q;
  logic             rx_s_q;
  logic [1:0]       settle_q;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q,   shift_d;
  logic             perr_q,    perr_d;
  logic             armed_q,   armed_d;
  logic [7:0]       dout_q,    dout_d;
  logic             strobe_q,  strobe_d;
  logic             rx_err_q,  rx_err_d;

  logic             expired;

  // Bring rx_in into the clock domain; settle_q marks when rx_s_q first
  // reflects the real line rather than the reset value, so a line held low
  // across reset release cannot arm the receiver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      settle_q  <= 2'b00;
    end else begin
      rx_meta_q <= bus.rx_in;
      rx_s_q    <= rx_meta_q;
      settle_q  <= {settle_q[0], 1'b1};
    end
  end

  // Receiver state register and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      perr_q    <= 1'b0;
      armed_q   <= 1'b0;
      dout_q    <= 8'h00;
      strobe_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      armed_q   <= armed_d;
      dout_q    <= dout_d;
      strobe_q  <= strobe_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign expired = (cnt_q == '0);

  // Next-state and datapath: every sample is taken when the counter expires,
  // which lands mid-bit because the start phase only runs half a bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    armed_d   = armed_q;
    dout_d    = dout_q;
    strobe_d  = 1'b0;
    rx_err_d  = rx_err_q;

    if (state_q != S_IDLE && !expired) begin
      cnt_d = cnt_q - C_CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_s_q && settle_q[1]) begin
          armed_d = 1'b1;
        end
        if (!rx_s_q && armed_q) begin
          state_d = S_START;
          cnt_d   = C_CNT_HALF;
          armed_d = 1'b0;
        end
      end

      S_START: begin
        if (expired) begin
          if (rx_s_q) begin
            state_d = S_IDLE;          // glitch, not a real start bit
          end else begin
            state_d   = S_DATA;
            cnt_d     = C_CNT_FULL;
            bit_cnt_d = 3'd0;
          end
        end
      end

      S_DATA: begin
        if (expired) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = C_CNT_FULL;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (expired) begin
          perr_d  = ~(^{shift_q, rx_s_q});   // odd total count of ones
          cnt_d   = C_CNT_FULL;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (expired) begin
          dout_d   = shift_q;
          strobe_d = 1'b1;
          rx_err_d = perr_q | ~rx_s_q;
          // a high stop bit lets the next start edge be taken right away;
          // a low one leaves us disarmed until the line idles high
          armed_d  = rx_s_q;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.dout        = dout_q;
  assign bus.data_strobe = strobe_q;
  assign bus.rx_error    = rx_err_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A serializer task drives
//                frames and queues the expected {rx_error, dout}; a monitor
//                pops and compares on every data_strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 62_500;
  localparam int B      = CLK_HZ / BAUD;   // 16 clocks per bit
  localparam int H      = B / 2;           // 8

  logic clk;
  logic rst;
  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQUENCY (CLK_HZ),
    .BAUD_RATE     (BAUD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         strobe_cnt = 0;
  int         busy_cycles = 0;
  int         last_strobe_cyc = 0;
  logic       prev_strobe = 1'b0;
  logic [8:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (bus.busy === 1'b1) busy_cycles++;
    if (bus.data_strobe === 1'b1) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      check_eq("strobe_width", {31'd0, prev_strobe}, 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("dout", {24'd0, bus.dout}, {24'd0, e[7:0]});
        check_eq("rx_error", {31'd0, bus.rx_error}, {31'd0, e[8]});
      end
    end
    prev_strobe = bus.data_strobe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    bus.rx_in = v;
    tick(B);
  endtask

  // Serialize one frame; line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_v,
                            input bit expect_it);
    logic [8:0] e;
    if (expect_it) begin
      e = {(!par_ok || !stop_v), b};
      sb.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par_ok ? ~^b : ^b);
    drive_bit(stop_v);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * B * 11) begin
      tick(1);
      n++;
    end
    check_eq(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t0;
    int         n0;
    int         lat;
    logic [7:0] b;
    logic [7:0] a5;

    // ---------------- reset ----------------
    bus.rx_in = 1'b1;
    rst = 1'b0;
    #80;
    rst = 1'b1;
    tick(2);
    check_eq("rst_dout", {24'd0, bus.dout}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_strobe", {31'd0, bus.data_strobe}, 32'd0);
    check_eq("rst_rx_error", {31'd0, bus.rx_error}, 32'd0);
    tick(4);

    // ---------------- single frame 0xA5: latency and busy length ----------------
    busy_cycles = 0;
    n0 = strobe_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    tick(B);
    drain("a5_drain");
    lat = last_strobe_cyc - t0;
    check_eq("a5_strobes", strobe_cnt - n0, 32'd1);
    check_eq("a5_latency_in_2+H+10B_pm2", {31'd0, (lat >= 2 + H + 10 * B - 2) && (lat <= 2 + H + 10 * B + 2)}, 32'd1);
    check_eq("a5_busy_len_about_10.5_bits", {31'd0, (busy_cycles >= H + 10 * B - 2) && (busy_cycles <= H + 10 * B + 2)}, 32'd1);
    if (!((lat >= 2 + H + 10 * B - 2) && (lat <= 2 + H + 10 * B + 2)))
      $display("  latency was %0d clocks", lat);

    // ---------------- random bytes with gaps, then back-to-back ----------------
    n0 = strobe_cnt;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b1, 1'b1);
      tick($urandom_range(20, 300));
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b1, 1'b1);
    end
    tick(B);
    drain("stream_drain");
    check_eq("stream_strobes", strobe_cnt - n0, 32'd24);

    // ---------------- parity error then clean frame ----------------
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    tick(2 * B);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    tick(B);
    drain("parity_drain");

    // ---------------- framing error, line held low ----------------
    n0 = strobe_cnt;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    tick(3 * B);
    bus.rx_in = 1'b1;
    tick(4 * B);
    drain("framing_drain");
    check_eq("framing_one_strobe", strobe_cnt - n0, 32'd1);
    send_frame(8'h12, 1'b1, 1'b1, 1'b1);
    tick(B);
    drain("after_framing_drain");

    // ---------------- glitch shorter than half a bit ----------------
    busy_cycles = 0;
    n0 = strobe_cnt;
    bus.rx_in = 1'b0;
    tick(6);
    bus.rx_in = 1'b1;
    tick(4 * B);
    check_eq("glitch_busy_pulsed", {31'd0, busy_cycles > 0}, 32'd1);
    check_eq("glitch_no_strobe", strobe_cnt - n0, 32'd0);
    check_eq("glitch_busy_idle", {31'd0, bus.busy}, 32'd0);

    // ---------------- reset four bits into frame 0xA5 ----------------
    n0 = strobe_cnt;
    a5 = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(a5[i]);
    rst = 1'b0;
    tick(2);
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midrst_dout", {24'd0, bus.dout}, 32'd0);
    check_eq("midrst_rx_error", {31'd0, bus.rx_error}, 32'd0);
    tick(B - 2);
    for (int i = 4; i < 7; i++) drive_bit(a5[i]);
    bus.rx_in = a5[7];
    tick(H);
    rst = 1'b1;
    tick(B - H);
    drive_bit(~^a5);
    drive_bit(1'b1);
    tick(2 * B);
    check_eq("midrst_no_strobe", strobe_cnt - n0, 32'd0);
    check_eq("midrst_busy_after", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    tick(B);
    drain("after_reset_drain");
    check_eq("after_reset_strobes", strobe_cnt - n0, 32'd1);

    check_eq("final_queue_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
